// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// seg_scan_ctrl: multiplexes one 7-segment decoder across NUM_DIGITS common-anode digits,
// with a double-buffered frame that commits only at the digit-0 boundary. Rev 1.0
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int MAX_CNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] SHOW_END  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES - 1);

  typedef enum logic [0:0] {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic                    run;
  logic                    commit;
  logic                    pending_nx;

  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_blank, sh_dp;
  logic [4*NUM_DIGITS-1:0] act_data, act_data_nx;
  logic [NUM_DIGITS-1:0]   act_blank, act_blank_nx;
  logic [NUM_DIGITS-1:0]   act_dp, act_dp_nx;

  logic [3:0]              nibble_nx;
  logic [NUM_DIGITS-1:0]   an_n_nx;
  logic                    dp_n_nx;
  logic                    frame_start_nx;

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    idx_nx         = idx;
    commit         = 1'b0;
    pending_nx     = pending | load;
    act_data_nx    = act_data;
    act_blank_nx   = act_blank;
    act_dp_nx      = act_dp;
    an_n_nx        = '1;
    dp_n_nx        = 1'b1;
    nibble_nx      = nibble;
    frame_start_nx = 1'b0;

    // run gates the first edge after reset release, so digit 0 lights GUARD_CYCLES+1 edges later
    if (run) begin
      case (state)
        SHOW: begin
          if (cnt == SHOW_END) begin
            state_nx = GUARD;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == GUARD_END) begin
            state_nx = SHOW;
            cnt_nx   = '0;
            idx_nx   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
            commit   = (idx == LAST_IDX);
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      endcase
    end

    // A load landing on the commit edge bypasses the shadow so the newest value wins
    if (commit) begin
      pending_nx = 1'b0;
      if (load) begin
        act_data_nx  = data_in;
        act_blank_nx = blank_in;
        act_dp_nx    = dp_in;
      end else if (pending) begin
        act_data_nx  = sh_data;
        act_blank_nx = sh_blank;
        act_dp_nx    = sh_dp;
      end
    end

    if (state_nx == SHOW) begin
      nibble_nx      = act_data_nx[{idx_nx, 2'b00} +: 4];
      dp_n_nx        = ~act_dp_nx[idx_nx];
      frame_start_nx = (state == GUARD) && (idx_nx == '0);
      if (!act_blank_nx[idx_nx]) begin
        an_n_nx = ~(NUM_DIGITS'(1) << idx_nx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= GUARD;
      cnt         <= '0;
      idx         <= LAST_IDX;
      run         <= 1'b0;
      pending     <= 1'b0;
      sh_data     <= '0;
      sh_blank    <= '0;
      sh_dp       <= '0;
      act_data    <= '0;
      act_blank   <= '0;
      act_dp      <= '0;
      nibble      <= '0;
      an_n        <= '1;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      run         <= 1'b1;
      pending     <= pending_nx;
      act_data    <= act_data_nx;
      act_blank   <= act_blank_nx;
      act_dp      <= act_dp_nx;
      nibble      <= nibble_nx;
      an_n        <= an_n_nx;
      dp_n        <= dp_n_nx;
      frame_start <= frame_start_nx;
      if (load) begin
        sh_data  <= data_in;
        sh_blank <= blank_in;
        sh_dp    <= dp_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl (4 digits, 4-cycle dwell, 2-cycle guard).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic [3:0]  dp_in;
  logic [3:0]  nibble;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_start;
  logic        pending;

  int errors = 0;
  int checks = 0;

  logic [9:0] cap [24];

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .GUARD_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .nibble     (nibble),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_start(frame_start),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    data_in  = d;
    blank_in = b;
    dp_in    = p;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  // Advance until frame_start is seen in the sampled cycle, bounded
  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    tick();
    while (frame_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout frame_start=%b required=1 within 40 cycles", tag, frame_start);
    end
  endtask

  // Record 24 samples starting with the current one: {an_n, nibble, dp_n, frame_start}
  task automatic capture_frame();
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      cap[c] = {an_n, nibble, dp_n, frame_start};
    end
  endtask

  function automatic logic [9:0] exp_sample(input logic [15:0] d, input logic [3:0] b,
                                            input logic [3:0] p, input int c);
    int         k;
    int         ph;
    logic [3:0] an;
    logic [3:0] nib;
    logic       dpn;
    k   = c / 6;
    ph  = c % 6;
    an  = 4'hF;
    dpn = 1'b1;
    nib = d[k*4 +: 4];
    if (ph < 4) begin
      if (!b[k]) an = ~(4'b0001 << k);
      dpn = ~p[k];
    end
    return {an, nib, dpn, (c == 0)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (an_n !== 4'hF)       begin errors++; $display("FAIL rst_an_n got=%h exp=F", an_n); end
    checks++; if (dp_n !== 1'b1)       begin errors++; $display("FAIL rst_dp_n got=%b exp=1", dp_n); end
    checks++; if (nibble !== 4'h0)     begin errors++; $display("FAIL rst_nibble got=%h exp=0", nibble); end
    checks++; if (pending !== 1'b0)    begin errors++; $display("FAIL rst_pending got=%b exp=0", pending); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got=%b exp=0", frame_start); end
    rst_n = 1'b1;
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL rel_edge1_an_n got=%h exp=F", an_n); end
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL rel_edge2_an_n got=%h exp=F", an_n); end
    tick();
    checks++; if (an_n !== 4'hE) begin errors++; $display("FAIL rel_edge3_an_n got=%h exp=E", an_n); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rel_edge3_fs got=%b exp=1", frame_start); end
    capture_frame();
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (cap[c] !== exp_sample(16'h0000, 4'h0, 4'h0, c)) begin
        errors++;
        $display("FAIL reset_frame c=%0d got=%h exp=%h", c, cap[c], exp_sample(16'h0000, 4'h0, 4'h0, c));
      end
    end
  endtask

  task automatic test_load_commit();
    logic pend_ok;
    wait_fs("load_sync");
    tick();
    tick();
    do_load(16'h3A95, 4'h0, 4'b0001);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL load_pending got=%b exp=1", pending); end
    pend_ok = 1'b1;
    for (int n = 0; n < 40 && frame_start !== 1'b1; n++) begin
      if (pending !== 1'b1) pend_ok = 1'b0;
      tick();
    end
    checks++; if (pend_ok !== 1'b1)  begin errors++; $display("FAIL load_pending_hold got=0 exp=1"); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL load_commit_fs got=%b exp=1", frame_start); end
    checks++; if (pending !== 1'b0)  begin errors++; $display("FAIL load_commit_pending got=%b exp=0", pending); end
    capture_frame();
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (cap[c] !== exp_sample(16'h3A95, 4'h0, 4'b0001, c)) begin
        errors++;
        $display("FAIL load_frame c=%0d got=%h exp=%h", c, cap[c], exp_sample(16'h3A95, 4'h0, 4'b0001, c));
      end
    end
  endtask

  task automatic test_double_load();
    wait_fs("dbl_sync");
    tick();
    tick();
    tick();
    do_load(16'h1111, 4'h0, 4'h0);
    tick();
    do_load(16'h2222, 4'h0, 4'h0);
    wait_fs("dbl_commit");
    capture_frame();
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (cap[c] !== exp_sample(16'h2222, 4'h0, 4'h0, c)) begin
        errors++;
        $display("FAIL double_load_frame c=%0d got=%h exp=%h", c, cap[c], exp_sample(16'h2222, 4'h0, 4'h0, c));
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_fs("b2b_sync");
    for (int i = 0; i < 10; i++) tick();
    do_load(16'h1111, 4'h0, 4'h0);
    for (int i = 0; i < 12; i++) tick();
    do_load(16'h4444, 4'h0, 4'h0);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL b2b_commit_fs got=%b exp=1", frame_start); end
    checks++; if (pending !== 1'b0)     begin errors++; $display("FAIL b2b_pending got=%b exp=0", pending); end
    capture_frame();
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (cap[c] !== exp_sample(16'h4444, 4'h0, 4'h0, c)) begin
        errors++;
        $display("FAIL b2b_frame c=%0d got=%h exp=%h", c, cap[c], exp_sample(16'h4444, 4'h0, 4'h0, c));
      end
    end
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL b2b_period_fs got=%b exp=1", frame_start); end
  endtask

  task automatic test_blank();
    tick();
    do_load(16'h8765, 4'b1010, 4'h0);
    wait_fs("blank_commit");
    capture_frame();
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (cap[c] !== exp_sample(16'h8765, 4'b1010, 4'h0, c)) begin
        errors++;
        $display("FAIL blank_frame c=%0d got=%h exp=%h", c, cap[c], exp_sample(16'h8765, 4'b1010, 4'h0, c));
      end
    end
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL blank_period_fs got=%b exp=1", frame_start); end
  endtask

  task automatic test_mid_reset();
    do_load(16'h1111, 4'h0, 4'h0);
    for (int i = 0; i < 12; i++) tick();
    checks++; if (an_n !== 4'hB) begin errors++; $display("FAIL midrst_pre_an_n got=%h exp=B", an_n); end
    rst_n = 1'b0;
    #1;
    checks++; if (an_n !== 4'hF)    begin errors++; $display("FAIL midrst_an_n got=%h exp=F", an_n); end
    checks++; if (nibble !== 4'h0)  begin errors++; $display("FAIL midrst_nibble got=%h exp=0", nibble); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL midrst_pending got=%b exp=0", pending); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL midrst_guard_an_n got=%h exp=F", an_n); end
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL midrst_fs got=%b exp=1", frame_start); end
    capture_frame();
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (cap[c] !== exp_sample(16'h0000, 4'h0, 4'h0, c)) begin
        errors++;
        $display("FAIL midrst_frame c=%0d got=%h exp=%h", c, cap[c], exp_sample(16'h0000, 4'h0, 4'h0, c));
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    blank_in = '0;
    dp_in    = '0;
    test_reset();
    test_load_commit();
    test_double_load();
    test_back_to_back();
    test_blank();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
